fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter BTB_IDX_W, default 4, BTB index width (2^BTB_IDX_W entries).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port StallF  input  1  hold PC (data hazard).
REQ-006 SHALL have port RedirectE  input  1  mispredict/redirect from Execute.
REQ-007 SHALL have port RedirectPCE  input  32  corrected fetch address.
REQ-008 SHALL have port BranchE  input  1  resolved branch/jump in Execute, BTB update strobe.
REQ-009 SHALL have port ActualTakenE  input  1  resolved direction.
REQ-010 SHALL have port PCE  input  32  PC of resolved branch.
REQ-011 SHALL have port TargetE  input  32  resolved target.
REQ-012 SHALL have port PCF  output  32  current fetch address (registered).
REQ-013 SHALL have port PCPlus4F  output  32  PCF + 4.
REQ-014 SHALL have port TakenF  output  1  predicted taken for PCF.

Function
REQ-015 PCPlus4F SHALL equal PCF + 4 modulo 2^32, combinational.
REQ-016 Next-PC priority SHALL be: RedirectE -> RedirectPCE; else StallF -> hold; else TakenF -> BTB target; else PCPlus4F.
REQ-017 RedirectE SHALL override StallF in the same cycle.
REQ-018 Bit 0 of every value loaded into PCF SHALL be forced to 0.
REQ-019 BTB index SHALL be PC[BTB_IDX_W+1:2]; tag SHALL be PC[31:BTB_IDX_W+2]; entry = valid, tag, 32-bit target, 2-bit counter.
REQ-020 Lookup SHALL be combinational on PCF; hit = valid & tag match; TakenF = hit & counter[1].
REQ-021 Counter encoding SHALL be 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-022 On BranchE with hit on PCE: counter SHALL increment on ActualTakenE and decrement otherwise, saturating at 11 and 00; target SHALL be overwritten with TargetE when ActualTakenE.
REQ-023 On BranchE with miss and ActualTakenE: entry SHALL be allocated (valid=1, tag, target=TargetE, counter=10), replacing any occupant.
REQ-024 On BranchE with miss and not taken: no BTB change.
REQ-025 BTB updates SHALL occur at the clock edge regardless of StallF and RedirectE.
REQ-026 Lookup and update to the same index in one cycle: lookup SHALL see pre-update contents; the update SHALL be visible from the next cycle.
REQ-027 TargetE/RedirectPCE wrap-around SHALL be taken as-is; no range checks.

Reset
REQ-028 On rst low, asynchronously: PCF = RESET_PC, all valid bits = 0, counters = 00, targets/tags = 0.
REQ-029 During reset, TakenF SHALL be 0 and PCPlus4F = RESET_PC + 4.
REQ-030 Reset asserted mid-operation SHALL discard pending redirect/update; first edge after release fetches RESET_PC + 4 (or redirect/stall per REQ-016).

Configuration
REQ-031 Macro FETCH_BTB_EN defined: BTB and prediction as above.
REQ-032 Macro FETCH_BTB_EN undefined: no BTB storage, TakenF tied 0, next PC = RedirectPCE / hold / PCPlus4F, BranchE, ActualTakenE, PCE, TargetE ignored.

Structure
REQ-033 Shared package SHALL hold: BTB entry struct, counter encoding constants, default RESET_PC.
REQ-034 BTB storage, lookup and update SHALL be one sub-module fetch_btb; fetch_unit holds the PC register and next-PC mux.

Verification
REQ-035 Reset with RESET_PC=0x100, release, no stall -> PCF 0x100, 0x104, 0x108; TakenF=0.
REQ-036 StallF=1 and RedirectE=1, RedirectPCE=0x2001 in the same cycle -> next PCF=0x2000.
REQ-037 BranchE, PCE=0x40, ActualTakenE=1, TargetE=0x80 -> when PCF=0x40 later: TakenF=1, next PCF=0x80.
REQ-038 Same branch resolved not-taken twice after allocation -> counter 10->01->00; TakenF=0 at 0x40, next PCF=0x44; third not-taken keeps 00.
REQ-039 PCE=0x40 and PCE=0x80 (same index, BTB_IDX_W=4) both taken in turn -> 0x80 evicts 0x40; PCF=0x40 then gives TakenF=0.
REQ-040 Build without FETCH_BTB_EN, repeat REQ-037 -> TakenF=0, next PCF=0x44.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: BTB entry layout,
// 2-bit counter encodings and the default reset PC.
package fetch_pkg;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Tag sized for the smallest index width; unused high bits stay 0.
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [31:0] target;
    logic [1:0]  ctr;
  } btb_entry_t;

endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer with 2-bit counters.
// Lookup is combinational on the fetch PC; update lands at the edge.
module fetch_btb
  import fetch_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_pc,
  output logic        o_taken,
  output logic [31:0] o_target,
  input  logic        i_upd,
  input  logic        i_act,
  input  logic [31:0] i_upd_pc,
  input  logic [31:0] i_upd_tgt
);

  localparam int N = 1 << IDX_W;

  btb_entry_t r_btb [N];

  logic [IDX_W-1:0] w_lidx;
  logic [IDX_W-1:0] w_uidx;
  btb_entry_t       w_lent;
  btb_entry_t       w_uent;
  btb_entry_t       w_new;
  logic             w_lhit;
  logic             w_uhit;
  logic             w_we;
  logic             w_unused;

  function automatic logic [29:0] tag_of(
    input logic [31:0] pc
  );
    return 30'(pc >> (IDX_W + 2));
  endfunction

  assign w_lidx   = i_pc[IDX_W+1:2];
  assign w_uidx   = i_upd_pc[IDX_W+1:2];
  assign w_lent   = r_btb[w_lidx];
  assign w_uent   = r_btb[w_uidx];
  assign w_lhit   = w_lent.valid &&
                    (w_lent.tag == tag_of(i_pc));
  assign w_uhit   = w_uent.valid &&
                    (w_uent.tag == tag_of(i_upd_pc));
  assign o_taken  = w_lhit & w_lent.ctr[1];
  assign o_target = w_lent.target;
  assign w_we     = i_upd & (w_uhit | i_act);
  assign w_unused = ^{i_pc[1:0], i_upd_pc[1:0]};

  always_comb begin
    w_new = w_uent;
    if (w_uhit) begin
      if (i_act) begin
        w_new.target = i_upd_tgt;
        if (w_uent.ctr != CTR_ST)
          w_new.ctr = w_uent.ctr + 2'd1;
      end else if (w_uent.ctr != CTR_SNT) begin
        w_new.ctr = w_uent.ctr - 2'd1;
      end
    end else begin
      w_new.valid  = 1'b1;
      w_new.tag    = tag_of(i_upd_pc);
      w_new.target = i_upd_tgt;
      w_new.ctr    = CTR_WT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++)
        r_btb[i] <= '0;
    end else if (w_we) begin
      r_btb[w_uidx] <= w_new;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register and next-PC select.
// Define FETCH_BTB_EN to enable BTB-based branch prediction.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter int          BTB_IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        RedirectE,
  input  logic [31:0] RedirectPCE,
  input  logic        BranchE,
  input  logic        ActualTakenE,
  input  logic [31:0] PCE,
  input  logic [31:0] TargetE,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        TakenF
);

  logic [31:0] r_pc;
  logic [31:0] w_next;
  logic [31:0] w_btb_tgt;

  assign PCF      = r_pc;
  assign PCPlus4F = r_pc + 32'd4;

`ifdef FETCH_BTB_EN
  fetch_btb #(
    .IDX_W (BTB_IDX_W)
  ) u_btb (
    .clk       (clk),
    .rst       (rst),
    .i_pc      (r_pc),
    .o_taken   (TakenF),
    .o_target  (w_btb_tgt),
    .i_upd     (BranchE),
    .i_act     (ActualTakenE),
    .i_upd_pc  (PCE),
    .i_upd_tgt (TargetE)
  );
`else
  logic w_unused;

  assign TakenF    = 1'b0;
  assign w_btb_tgt = '0;
  assign w_unused  = ^{BranchE, ActualTakenE,
                       PCE, TargetE};
`endif

  // Redirect outranks stall; several selects may be high together.
  always_comb begin
    w_next = PCPlus4F;
    priority case (1'b1)
      RedirectE: w_next = RedirectPCE;
      StallF:    w_next = r_pc;
      TakenF:    w_next = w_btb_tgt;
      default:   w_next = PCPlus4F;
    endcase
    w_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_pc <= {RESET_PC[31:1], 1'b0};
    else
      r_pc <= w_next;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus
// randomized traffic against an array-based BTB/PC model.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int          IW  = 4;
  localparam int          N   = 1 << IW;
`ifdef FETCH_BTB_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        StallF = 1'b0;
  logic        RedirectE = 1'b0;
  logic [31:0] RedirectPCE = '0;
  logic        BranchE = 1'b0;
  logic        ActualTakenE = 1'b0;
  logic [31:0] PCE = '0;
  logic [31:0] TargetE = '0;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        TakenF;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC  (RPC),
    .BTB_IDX_W (IW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .StallF       (StallF),
    .RedirectE    (RedirectE),
    .RedirectPCE  (RedirectPCE),
    .BranchE      (BranchE),
    .ActualTakenE (ActualTakenE),
    .PCE          (PCE),
    .TargetE      (TargetE),
    .PCF          (PCF),
    .PCPlus4F     (PCPlus4F),
    .TakenF       (TakenF)
  );

  // Reference model: PC plus a table of (valid, full upper PC, target, count)
  logic [31:0] m_pc;
  bit          m_v   [N];
  logic [31:0] m_tag [N];
  logic [31:0] m_tgt [N];
  int          m_ctr [N];

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    int i;
    i = m_idx(pc);
    return BTB && m_v[i] && (m_tag[i] == (pc >> (IW + 2)));
  endfunction

  function automatic bit m_taken(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
  endfunction

  task automatic m_reset();
    m_pc = RPC;
    for (int i = 0; i < N; i++) begin
      m_v[i] = 1'b0;
      m_tag[i] = '0;
      m_tgt[i] = '0;
      m_ctr[i] = 0;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_out();
    chk("pcf", PCF, m_pc);
    chk("pcplus4", PCPlus4F, m_pc + 32'd4);
    chk("takenf", {31'b0, TakenF}, {31'b0, m_taken(m_pc)});
  endtask

  // Called at a falling edge: check, drive, advance model, next falling edge
  task automatic step(input bit rd, input logic [31:0] rp,
                      input bit st, input bit br, input bit at,
                      input logic [31:0] pe, input logic [31:0] tg);
    logic [31:0] nxt;
    int i;
    chk_out();
    RedirectE = rd; RedirectPCE = rp; StallF = st;
    BranchE = br; ActualTakenE = at; PCE = pe; TargetE = tg;
    if (rd)                nxt = rp;
    else if (st)           nxt = m_pc;
    else if (m_taken(m_pc)) nxt = m_tgt[m_idx(m_pc)];
    else                   nxt = m_pc + 32'd4;
    nxt[0] = 1'b0;
    if (BTB && br) begin
      i = m_idx(pe);
      if (m_hit(pe)) begin
        if (at) begin
          m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
          m_tgt[i] = tg;
        end else begin
          m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (at) begin
        m_v[i] = 1'b1;
        m_tag[i] = pe >> (IW + 2);
        m_tgt[i] = tg;
        m_ctr[i] = 2;
      end
    end
    m_pc = nxt;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, '0, 0, 0, 0, '0, '0);
  endtask

  task automatic go(input logic [31:0] pc);
    step(1, pc, 0, 0, 0, '0, '0);
  endtask

  task automatic resolve(input bit at, input logic [31:0] pe,
                         input logic [31:0] tg, input logic [31:0] rp);
    step(1, rp, 0, 1, at, pe, tg);
  endtask

  // Async reset asserted away from the edge, released on a falling edge
  task automatic do_reset();
    rst = 1'b0;
    #1;
    m_reset();
    chk("rst_pcf", PCF, RPC);
    chk("rst_pcplus4", PCPlus4F, RPC + 32'd4);
    chk("rst_taken", {31'b0, TakenF}, 32'd0);
    RedirectE = 0; StallF = 0; BranchE = 0; ActualTakenE = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] rp, pe, tg;
    bit rd, st, br, at;
    m_reset();
    @(negedge clk);
    do_reset();

    // Reset vector and sequential fetch
    idle(); idle(); idle();
    chk("seq_pcf", PCF, RPC + 32'd12);

    // Redirect beats stall, bit 0 cleared
    step(1, 32'h2001, 1, 0, 0, '0, '0);
    chk("redir_stall", PCF, 32'h2000);
    step(0, '0, 1, 0, 0, '0, '0);
    chk("stall_hold", PCF, 32'h2000);

    // Allocate 0x40 -> 0x80 while redirecting to 0x40
    resolve(1, 32'h40, 32'h80, 32'h40);
    chk("alloc_taken", {31'b0, TakenF}, {31'b0, BTB});
    idle();
    chk("alloc_next", PCF, BTB ? 32'h80 : 32'h44);

    // Three not-taken: 10 -> 01 -> 00 -> 00
    resolve(0, 32'h40, 32'h0, 32'h10);
    resolve(0, 32'h40, 32'h0, 32'h10);
    resolve(0, 32'h40, 32'h0, 32'h40);
    chk("nt_taken", {31'b0, TakenF}, 32'd0);
    idle();
    chk("nt_next", PCF, 32'h44);
    // Saturated at 00: one taken gives 01, a second gives 10
    resolve(1, 32'h40, 32'h80, 32'h40);
    chk("sat_lo", {31'b0, TakenF}, 32'd0);
    resolve(1, 32'h40, 32'h80, 32'h40);
    chk("sat_up", {31'b0, TakenF}, {31'b0, BTB});

    // Same-index eviction by 0x80
    resolve(1, 32'h80, 32'h200, 32'h40);
    chk("evict_old", {31'b0, TakenF}, 32'd0);
    go(32'h80);
    chk("evict_new", {31'b0, TakenF}, {31'b0, BTB});
    idle();
    chk("evict_tgt", PCF, BTB ? 32'h200 : 32'h84);

    // Lookup and update to the looked-up entry in the same cycle
    go(32'h80);
    step(0, '0, 0, 1, 0, 32'h80, '0);
    go(32'h80);
    step(0, '0, 0, 1, 0, 32'h80, '0);
    chk("same_cyc", PCF, 32'h84);

    // PC wrap-around
    go(32'hFFFF_FFFC);
    idle();
    chk("wrap", PCF, 32'h0);

    // Mid-run reset, then randomized traffic
    step(1, 32'h300, 0, 1, 1, 32'h100, 32'h300);
    do_reset();
    idle();
    chk("post_rst", PCF, RPC + 32'd4);

    for (int n = 0; n < 600; n++) begin
      rd = ($urandom_range(0, 7) == 0);
      st = ($urandom_range(0, 3) == 0);
      br = ($urandom_range(0, 2) == 0);
      at = $urandom_range(0, 1) == 1;
      rp = $urandom & 32'h1FF;
      if ($urandom_range(0, 30) == 0) rp = 32'hFFFF_FFF8;
      pe = $urandom_range(0, 1) ? m_pc : ($urandom & 32'h1FC);
      tg = $urandom & 32'h1FF;
      if ($urandom_range(0, 40) == 0) tg = 32'hFFFF_FFFD;
      step(rd, rp, st, br, at, pe, tg);
      if ($urandom_range(0, 150) == 0) do_reset();
    end
    chk_out();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
